// File: rtl/dcache_ctrl_if.sv
// Bus bundle for dcache_ctrl: CPU load/store side plus the block-wide data memory side.
// slave is the cache's view; master is the view of the CPU/memory environment around it.
interface dcache_ctrl_if #(
  parameter int unsigned OFFSET_BITS = 2
);
  localparam int unsigned BLK_W = 8 << OFFSET_BITS;

  logic                  READ;
  logic                  WRITE;
  logic [7:0]            ADDRESS;
  logic [7:0]            WRITEDATA;
  logic [7:0]            READDATA;
  logic                  BUSYWAIT;
  logic                  MEM_READ;
  logic                  MEM_WRITE;
  logic [7-OFFSET_BITS:0] MEM_ADDRESS;
  logic [BLK_W-1:0]      MEM_WRITEDATA;
  logic [BLK_W-1:0]      MEM_READDATA;
  logic                  MEM_BUSYWAIT;

  modport slave (
    input  READ, WRITE, ADDRESS, WRITEDATA, MEM_READDATA, MEM_BUSYWAIT,
    output READDATA, BUSYWAIT, MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA
  );

  modport master (
    output READ, WRITE, ADDRESS, WRITEDATA, MEM_READDATA, MEM_BUSYWAIT,
    input  READDATA, BUSYWAIT, MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA
  );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache with a stalling miss FSM.
// Define DCACHE_STATS_EN to add saturating HIT_COUNT/MISS_COUNT outputs.
module dcache_ctrl #(
  parameter int unsigned INDEX_BITS  = 3,
  parameter int unsigned OFFSET_BITS = 2
) (
  input  logic          CLK,
  input  logic          RESET,
  dcache_ctrl_if.slave  bus
`ifdef DCACHE_STATS_EN
  ,
  output logic [15:0]   HIT_COUNT,
  output logic [15:0]   MISS_COUNT
`endif
);
  localparam int unsigned TAG_BITS = 8 - INDEX_BITS - OFFSET_BITS;
  localparam int unsigned BLK_W    = 8 << OFFSET_BITS;
  localparam int unsigned NLINES   = 1 << INDEX_BITS;

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_WRITEBACK = 2'd1;
  localparam logic [1:0] S_FETCH     = 2'd2;
  localparam logic [1:0] S_UPDATE    = 2'd3;

  logic [1:0]                    r_state;
  logic [1:0]                    w_next_state;
  logic [BLK_W-1:0]              r_data [NLINES];
  logic [TAG_BITS-1:0]           r_tag  [NLINES];
  logic [NLINES-1:0]             r_valid;
  logic [NLINES-1:0]             r_dirty;
  // Block address of the miss being serviced, captured when the miss is taken
  // so a CPU that drops or changes its request cannot redirect the fill.
  logic [TAG_BITS+INDEX_BITS-1:0] r_miss_blk;

  logic [TAG_BITS-1:0]    w_tag;
  logic [INDEX_BITS-1:0]  w_idx;
  logic [OFFSET_BITS-1:0] w_off;
  logic [TAG_BITS-1:0]    w_miss_tag;
  logic [INDEX_BITS-1:0]  w_miss_idx;
  logic [BLK_W-1:0]       w_line;
  logic                   w_req;
  logic                   w_hit;
  logic                   w_miss;
  logic                   w_wr_hit;

  assign w_tag      = bus.ADDRESS[7 -: TAG_BITS];
  assign w_idx      = bus.ADDRESS[OFFSET_BITS +: INDEX_BITS];
  assign w_off      = bus.ADDRESS[OFFSET_BITS-1:0];
  assign w_miss_tag = r_miss_blk[TAG_BITS+INDEX_BITS-1 -: TAG_BITS];
  assign w_miss_idx = r_miss_blk[INDEX_BITS-1:0];
  assign w_line     = r_data[w_idx];

  assign w_req    = bus.READ | bus.WRITE;
  assign w_hit    = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_miss   = (r_state == S_IDLE) && w_req && !w_hit;
  assign w_wr_hit = (r_state == S_IDLE) && bus.WRITE && w_hit;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:      if (w_req && !w_hit)
                     w_next_state = (r_valid[w_idx] && r_dirty[w_idx]) ? S_WRITEBACK : S_FETCH;
      S_WRITEBACK: if (!bus.MEM_BUSYWAIT) w_next_state = S_FETCH;
      S_FETCH:     if (!bus.MEM_BUSYWAIT) w_next_state = S_UPDATE;
      S_UPDATE:    w_next_state = S_IDLE;
      default:     w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_ff @(posedge CLK) begin
    if (w_miss) r_miss_blk <= {w_tag, w_idx};
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (r_state == S_UPDATE) begin
      r_valid[w_miss_idx] <= 1'b1;
      r_dirty[w_miss_idx] <= 1'b0;
    end else if (w_wr_hit) begin
      r_dirty[w_idx] <= 1'b1;
    end
  end

  // Data and tag arrays carry no reset; validity alone qualifies their contents.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      if (r_state == S_UPDATE) begin
        r_data[w_miss_idx] <= bus.MEM_READDATA;
        r_tag[w_miss_idx]  <= w_miss_tag;
      end else if (w_wr_hit) begin
        r_data[w_idx][{w_off, 3'b000} +: 8] <= bus.WRITEDATA;
      end
    end
  end

  assign bus.MEM_READ      = (r_state == S_FETCH);
  assign bus.MEM_WRITE     = (r_state == S_WRITEBACK);
  assign bus.MEM_ADDRESS   = (r_state == S_WRITEBACK) ? {r_tag[w_miss_idx], w_miss_idx} : r_miss_blk;
  assign bus.MEM_WRITEDATA = r_data[w_miss_idx];

  assign bus.BUSYWAIT = (r_state != S_IDLE) || (w_req && !w_hit);
  assign bus.READDATA = (bus.READ && !bus.WRITE && w_hit && !RESET) ? w_line[{w_off, 3'b000} +: 8] : '0;

`ifdef DCACHE_STATS_EN
  // A request whose miss was just serviced re-evaluates as a hit; r_missed
  // keeps that completion from being counted as a hit as well.
  logic r_missed;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      HIT_COUNT  <= '0;
      MISS_COUNT <= '0;
      r_missed   <= 1'b0;
    end else if (r_state == S_IDLE) begin
      if (w_req && !w_hit) begin
        r_missed <= 1'b1;
        if (MISS_COUNT != '1) MISS_COUNT <= MISS_COUNT + 16'd1;
      end else if (w_req) begin
        if (!r_missed && HIT_COUNT != '1) HIT_COUNT <= HIT_COUNT + 16'd1;
        r_missed <= 1'b0;
      end else begin
        r_missed <= 1'b0;
      end
    end
  end
`endif
endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl: directed cases then random traffic against a byte-level
// architectural memory model with per-index residency bookkeeping.
module tb_dcache_ctrl;
  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  dcache_ctrl_if #(.OFFSET_BITS(2)) bus ();

`ifdef DCACHE_STATS_EN
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;
`endif

  dcache_ctrl #(.INDEX_BITS(3), .OFFSET_BITS(2)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
`ifdef DCACHE_STATS_EN
    ,
    .HIT_COUNT  (hit_cnt),
    .MISS_COUNT (miss_cnt)
`endif
  );

  // Reference model: arch = what the CPU must observe, bk = what memory holds.
  logic [7:0] arch [256];
  logic [7:0] bk   [256];
  bit         res_v [8];
  logic [2:0] res_t [8];
  bit         res_d [8];
  int         exp_hits;
  int         exp_misses;

  int n_checks = 0;
  int n_errors = 0;

  // Memory device: a request lasts mem_lat cycles, data written on completion.
  logic [31:0] mem [64];
  int          mem_cnt = 0;
  int          mem_lat = 1;
  logic        mem_load;

  assign bus.MEM_BUSYWAIT = (bus.MEM_READ || bus.MEM_WRITE) && (mem_cnt < mem_lat - 1);
  assign bus.MEM_READDATA = mem[bus.MEM_ADDRESS];

  always @(posedge CLK) begin
    if (mem_load) begin
      for (int i = 0; i < 64; i++)
        mem[i] <= {bk[4*i+3], bk[4*i+2], bk[4*i+1], bk[4*i]};
      mem_cnt <= 0;
    end else if (bus.MEM_READ || bus.MEM_WRITE) begin
      if (bus.MEM_BUSYWAIT) mem_cnt <= mem_cnt + 1;
      else begin
        mem_cnt <= 0;
        if (bus.MEM_WRITE) mem[bus.MEM_ADDRESS] <= bus.MEM_WRITEDATA;
      end
    end else begin
      mem_cnt <= 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic sync();
    @(posedge CLK);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      res_v[i] = 1'b0;
      res_d[i] = 1'b0;
    end
    for (int i = 0; i < 256; i++) arch[i] = bk[i];
    exp_hits   = 0;
    exp_misses = 0;
  endtask

  // Issue one request starting just after a posedge; returns just after the completion edge.
  task automatic do_req(input bit rd, input bit wr, input logic [7:0] addr,
                        input logic [7:0] wd, input bit drop);
    logic [2:0]  idx;
    logic [2:0]  tag;
    logic [2:0]  otag;
    bit          hit, evict, dropped, done, wb_seen, rd_seen;
    int          exp_stall, stall, overlap;
    logic [5:0]  wb_addr, rd_addr;
    logic [31:0] wb_data, exp_wb;
    logic [7:0]  exp_rdata;

    idx     = addr[4:2];
    tag     = addr[7:5];
    otag    = res_t[idx];
    hit     = res_v[idx] && (res_t[idx] == tag);
    evict   = !hit && res_v[idx] && res_d[idx];
    dropped = drop && !hit;
    exp_stall = hit ? 0 : (evict ? 2 * mem_lat + 2 : mem_lat + 2);
    exp_wb  = {arch[{otag, idx, 2'd3}], arch[{otag, idx, 2'd2}],
               arch[{otag, idx, 2'd1}], arch[{otag, idx, 2'd0}]};
    exp_rdata = (rd && !wr && !dropped) ? arch[addr] : 8'h00;

    wb_seen = 0; rd_seen = 0; overlap = 0; stall = 0; done = 0;
    wb_addr = '0; rd_addr = '0; wb_data = '0;
    bus.READ = rd; bus.WRITE = wr; bus.ADDRESS = addr; bus.WRITEDATA = wd;

    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge CLK);
      if (bus.MEM_READ && bus.MEM_WRITE) overlap++;
      if (bus.MEM_WRITE && !wb_seen) begin
        wb_seen = 1; wb_addr = bus.MEM_ADDRESS; wb_data = bus.MEM_WRITEDATA;
      end
      if (bus.MEM_READ && !rd_seen) begin
        rd_seen = 1; rd_addr = bus.MEM_ADDRESS;
      end
      if (!bus.BUSYWAIT) begin
        done = 1;
        check("readdata", bus.READDATA, exp_rdata);
      end else begin
        stall++;
      end
      sync();
      if (drop && stall == 1) begin
        bus.READ = 0; bus.WRITE = 0;
      end
    end
    if (!done) check("timeout", 1, 0);

    check("stall_cycles", stall, exp_stall);
    check("wb_issued", wb_seen, evict);
    if (evict) begin
      check("wb_addr", wb_addr, {otag, idx});
      check("wb_data", wb_data, exp_wb);
    end
    check("fetch_issued", rd_seen, !hit);
    if (!hit) check("fetch_addr", rd_addr, {tag, idx});
    check("mem_rw_excl", overlap, 0);

    if (!hit) begin
      if (evict)
        for (int b = 0; b < 4; b++) bk[{otag, idx, b[1:0]}] = arch[{otag, idx, b[1:0]}];
      res_v[idx] = 1; res_t[idx] = tag; res_d[idx] = 0;
      exp_misses++;
    end else begin
      exp_hits++;
    end
    if (wr && !dropped) begin
      arch[addr] = wd;
      res_d[idx] = 1;
    end
    bus.READ = 0; bus.WRITE = 0;
  endtask

  initial begin
    bit seen;
    bus.READ = 0; bus.WRITE = 0; bus.ADDRESS = '0; bus.WRITEDATA = '0;
    for (int i = 0; i < 256; i++) bk[i] = 8'($urandom);
    bk[4] = 8'hAA; bk[5] = 8'hBB; bk[6] = 8'hCC; bk[7] = 8'hDD;
    model_reset();

    RESET = 1; mem_load = 1;
    repeat (2) @(posedge CLK);
    #1 RESET = 0; mem_load = 0;
    @(negedge CLK);
    check("rst_busywait", bus.BUSYWAIT, 0);
    check("rst_mem_read", bus.MEM_READ, 0);
    check("rst_mem_write", bus.MEM_WRITE, 0);
    check("rst_readdata", bus.READDATA, 0);
    sync();

    mem_lat = 5;
    do_req(1, 0, 8'h05, 8'h00, 0);
    do_req(1, 0, 8'h06, 8'h00, 0);
    do_req(0, 1, 8'h04, 8'h5A, 0);
    do_req(1, 0, 8'h04, 8'h00, 0);
    do_req(1, 0, 8'h24, 8'h00, 0);
`ifdef DCACHE_STATS_EN
    check("hit_count", hit_cnt, 3);
    check("miss_count", miss_cnt, 2);
`endif

    // Reset while a fetch is outstanding, then the same address must miss again.
    bus.READ = 1; bus.ADDRESS = 8'h45;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge CLK);
      if (bus.MEM_READ) seen = 1;
      else sync();
    end
    check("rst_fetch_seen", seen, 1);
    sync();
    RESET = 1; bus.READ = 0;
    sync();
    RESET = 0;
    @(negedge CLK);
    check("midrst_mem_read", bus.MEM_READ, 0);
    check("midrst_mem_write", bus.MEM_WRITE, 0);
    check("midrst_busywait", bus.BUSYWAIT, 0);
    model_reset();
    sync();
    do_req(1, 0, 8'h45, 8'h00, 0);

    for (int n = 0; n < 300; n++) begin
      int unsigned op;
      logic [7:0] a;
      mem_lat = int'($urandom_range(1, 4));
      op = $urandom_range(0, 9);
      a  = {3'($urandom_range(0, 3)), 5'($urandom)};
      do_req(op < 5 || op == 9, op >= 5, a, 8'($urandom), $urandom_range(0, 9) == 0);
    end
`ifdef DCACHE_STATS_EN
    check("hit_count_rand", hit_cnt, 32'(exp_hits));
    check("miss_count_rand", miss_cnt, 32'(exp_misses));
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Direct-mapped, write-back, write-allocate data cache between the CPU load/store path and the block-wide data memory.
- On the CPU side it is the responder: it serves byte loads and stores, and the load results feed the register file write port.
- On the memory side it is the initiator of the READ/WRITE/BUSYWAIT handshake the data memory responds to.
- It stalls the CPU via BUSYWAIT on every miss.

Parameters:
- INDEX_BITS, 3, set index width; the cache has 2^INDEX_BITS lines.
- OFFSET_BITS, 2, byte offset width; a block is 2^OFFSET_BITS bytes, so BLK_W = 8<<OFFSET_BITS.
- TAG_BITS, 8-INDEX_BITS-OFFSET_BITS, derived; do not override.

Ports:
- CLK  in  1  clock
- RESET  in  1  synchronous, active-high reset
- READ  in  1  CPU load request, held high until BUSYWAIT low
- WRITE  in  1  CPU store request, held high until BUSYWAIT low
- ADDRESS  in  8  CPU byte address = {tag, index, offset}
- WRITEDATA  in  8  store data
- READDATA  out  8  load data
- BUSYWAIT  out  1  CPU stall
- MEM_READ  out  1  block fetch request
- MEM_WRITE  out  1  block writeback request
- MEM_ADDRESS  out  8-OFFSET_BITS  block address {tag, index}
- MEM_WRITEDATA  out  BLK_W  writeback block
- MEM_READDATA  in  BLK_W  fetched block, valid when MEM_BUSYWAIT falls
- MEM_BUSYWAIT  in  1  memory busy; high while a memory access is in progress

Behaviour:
- Reset and clocking:
  - Reset is synchronous on the CLK posedge with RESET=1.
  - Reset clears all valid and dirty bits, sets state to IDLE, and drives MEM_READ=0, MEM_WRITE=0 and READDATA=0.
  - Data and tag arrays are not cleared.
- Hit detection:
  - hit = valid[idx] & (tag[idx]==ADDRESS tag), evaluated combinationally.
- States and transitions:
  - IDLE:
    - BUSYWAIT = (READ|WRITE) & ~hit.
    - Miss with clean line -> FETCH. Miss with dirty line -> WRITEBACK.
  - WRITEBACK:
    - MEM_WRITE=1; MEM_ADDRESS={stored tag, idx}; MEM_WRITEDATA=line data.
    - Held until the first cycle MEM_BUSYWAIT=0, then -> FETCH.
  - FETCH:
    - MEM_READ=1; MEM_ADDRESS={ADDRESS tag, idx}.
    - Held until MEM_BUSYWAIT=0, then -> UPDATE.
  - UPDATE:
    - One cycle. The line takes MEM_READDATA, tag takes the ADDRESS tag, valid=1, dirty=0.
    - BUSYWAIT stays high. Next state IDLE, where the request re-evaluates as a hit.
- MEM_READ and MEM_WRITE are Moore outputs, so they deassert the cycle after leaving their state and are never high together.
- BUSYWAIT timing:
  - High in every non-IDLE state.
  - Falls in IDLE on the hit cycle; READ/WRITE with no miss never stalls.
- Read hit:
  - READDATA = selected byte of the line, combinational from ADDRESS.
  - 0 when READ=0 or on a miss.
- Write hit:
  - The byte at offset is written at the posedge where WRITE=1, hit=1, state=IDLE, RESET=0; dirty[idx] is set.
  - Zero stall cycles.
- Miss latency: clean miss = memory latency + 2 cycles; dirty miss = 2x memory latency + 2 cycles.
- READ and WRITE both high: treated as WRITE; READDATA=0.
- CPU drops its request mid-miss: the miss still completes the line fill; no CPU data is written.
- RESET mid-miss: state goes to IDLE at that edge and MEM_READ/MEM_WRITE deassert. The partial fill is discarded and the line is left invalid. The memory must tolerate the request drop.
- MEM_BUSYWAIT already 0 on the first cycle of WRITEBACK or FETCH: that state lasts exactly one cycle.

Optional Feature:
- Macro: DCACHE_STATS_EN.
- When defined:
  - Adds outputs HIT_COUNT[15:0] and MISS_COUNT[15:0], both cleared by RESET.
  - HIT_COUNT increments once per request that completes in IDLE without a preceding miss.
  - MISS_COUNT increments once on each IDLE->FETCH or IDLE->WRITEBACK transition.
  - Both counters saturate at 16'hFFFF.
- When undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then READ ADDRESS=8'h05 -> BUSYWAIT=1, MEM_READ=1, MEM_ADDRESS=6'h01. After memory returns 32'hDDCCBBAA with a 5-cycle latency: READDATA=8'hBB and BUSYWAIT=0 at cycle 7.
- After the fill, READ ADDRESS=8'h06 -> READDATA=8'hCC in the same cycle, BUSYWAIT never high, no memory request.
- WRITE 8'h5A to ADDRESS=8'h04 (hit) -> no stall; a subsequent READ of 8'h04 returns 8'h5A; dirty[1]=1.
- READ ADDRESS=8'h24 (same index, tag 1) -> MEM_WRITE=1, MEM_ADDRESS=6'h01, MEM_WRITEDATA=32'hDDCCBB5A; then MEM_READ=1 with MEM_ADDRESS=6'h09; finally READDATA is byte 0 of the new block.
- Assert RESET during FETCH -> MEM_READ=0 and BUSYWAIT=0 next cycle; a re-READ of the same address misses again.
- With DCACHE_STATS_EN, run the sequence above -> HIT_COUNT=3, MISS_COUNT=2 (counters reset by the final RESET are excluded; sample before it).
